cmp_select_ctrl: RTL and testbench

CMP_SELECT_CTRL -- requirements
Module: cmp_select_ctrl

---
 rtl/cmp_select_ctrl.sv | 130 +++++++++++++
 tb/tb_cmp_select_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_select_ctrl.sv
// cmp_select_ctrl: accepts one compare request (y, z and three candidate
// results), picks b/c/d by unsigned y<z / y>z / y==z, and presents the
// result with a valid/ready handshake. Per-branch hit counters saturate
// and can be cleared without disturbing the request flow.
module cmp_select_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_y,
    input  logic [3:0]       in_z,
    input  logic [1:0]       in_b,
    input  logic [1:0]       in_c,
    input  logic [1:0]       in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_a,
    output logic [1:0]       out_sel,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_lt,
    output logic [CNT_W-1:0] cnt_gt,
    output logic [CNT_W-1:0] cnt_eq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] SEL_LT = 2'd0;
    localparam logic [1:0] SEL_GT = 2'd1;
    localparam logic [1:0] SEL_EQ = 2'd2;

    state_t     state_reg;
    logic [3:0] y_reg;
    logic [3:0] z_reg;
    logic [1:0] b_reg;
    logic [1:0] c_reg;
    logic [1:0] d_reg;
    logic [1:0] out_a_reg;
    logic [1:0] out_sel_reg;
    logic [1:0] sel_next;
    logic [1:0] a_next;

    logic [CNT_W-1:0] cnt_reg [3];

    // Branch decision on the captured operands; less-than wins, then greater-than.
    always_comb begin
        sel_next = SEL_EQ;
        a_next   = d_reg;
        if (y_reg < z_reg) begin
            sel_next = SEL_LT;
            a_next   = b_reg;
        end else if (y_reg > z_reg) begin
            sel_next = SEL_GT;
            a_next   = c_reg;
        end
    end

    // Control FSM: capture in IDLE, decide in EVAL, present in HOLD until taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            y_reg       <= '0;
            z_reg       <= '0;
            b_reg       <= '0;
            c_reg       <= '0;
            d_reg       <= '0;
            out_a_reg   <= '0;
            out_sel_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        y_reg     <= in_y;
                        z_reg     <= in_z;
                        b_reg     <= in_b;
                        c_reg     <= in_c;
                        d_reg     <= in_d;
                        state_reg <= EVAL;
                    end
                end
                EVAL: begin
                    out_a_reg   <= a_next;
                    out_sel_reg <= sel_next;
                    state_reg   <= HOLD;
                end
                HOLD: begin
                    // Result registers are left as-is after the transfer.
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Saturating hit counters, one per branch; clear beats a same-edge hit.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic hit;
            assign hit = (state_reg == EVAL) && (sel_next == 2'(gi));

            // Counter gi advances on the EVAL edge that takes branch gi.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    cnt_reg[gi] <= '0;
                end else if (clr_cnt) begin
                    cnt_reg[gi] <= '0;
                end else if (hit && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    // Ready is withheld while reset is asserted, and rises as soon as it releases.
    assign in_ready  = (state_reg == IDLE) && !reset;
    assign out_valid = (state_reg == HOLD);
    assign out_a     = out_a_reg;
    assign out_sel   = out_sel_reg;
    assign cnt_lt    = cnt_reg[SEL_LT];
    assign cnt_gt    = cnt_reg[SEL_GT];
    assign cnt_eq    = cnt_reg[SEL_EQ];

endmodule

// File: tb/tb_cmp_select_ctrl.sv
// Testbench for cmp_select_ctrl: two instances (8-bit and 2-bit counters)
// share one stimulus stream; results and counts are predicted by a simple
// transaction-level model.
module tb_cmp_select_ctrl;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_y;
    logic [3:0] in_z;
    logic [1:0] in_b;
    logic [1:0] in_c;
    logic [1:0] in_d;
    logic       out_ready;
    logic       clr_cnt;

    logic       in_ready_w, in_ready_n;
    logic       out_valid_w, out_valid_n;
    logic [1:0] out_a_w, out_a_n;
    logic [1:0] out_sel_w, out_sel_n;
    logic [7:0] cnt_lt_w, cnt_gt_w, cnt_eq_w;
    logic [1:0] cnt_lt_n, cnt_gt_n, cnt_eq_n;

    int total = 0;
    int bad   = 0;

    // Model state: unbounded hit counts, saturated only when compared.
    int m_cnt [3];
    logic [1:0] m_a;
    logic [1:0] m_sel;

    cmp_select_ctrl #(.CNT_W(8)) u_dut_w (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_y(in_y), .in_z(in_z), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_a(out_a_w),
        .out_sel(out_sel_w), .clr_cnt(clr_cnt),
        .cnt_lt(cnt_lt_w), .cnt_gt(cnt_gt_w), .cnt_eq(cnt_eq_w)
    );

    cmp_select_ctrl #(.CNT_W(2)) u_dut_n (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_y(in_y), .in_z(in_z), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_a(out_a_n),
        .out_sel(out_sel_n), .clr_cnt(clr_cnt),
        .cnt_lt(cnt_lt_n), .cnt_gt(cnt_gt_n), .cnt_eq(cnt_eq_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check_counts(input string tag);
        check({tag, " cnt_lt8"}, 32'(cnt_lt_w), 32'(sat(m_cnt[0], 255)));
        check({tag, " cnt_gt8"}, 32'(cnt_gt_w), 32'(sat(m_cnt[1], 255)));
        check({tag, " cnt_eq8"}, 32'(cnt_eq_w), 32'(sat(m_cnt[2], 255)));
        check({tag, " cnt_lt2"}, 32'(cnt_lt_n), 32'(sat(m_cnt[0], 3)));
        check({tag, " cnt_gt2"}, 32'(cnt_gt_n), 32'(sat(m_cnt[1], 3)));
        check({tag, " cnt_eq2"}, 32'(cnt_eq_n), 32'(sat(m_cnt[2], 3)));
    endtask

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic junk_inputs();
        in_y = 4'($urandom);
        in_z = 4'($urandom);
        in_b = 2'($urandom);
        in_c = 2'($urandom);
        in_d = 2'($urandom);
    endtask

    // One full request: accept, evaluate (optionally clearing counters on that
    // edge), hold for hold_cycles with out_ready low, then hand off.
    task automatic do_txn(input logic [3:0] y, input logic [3:0] z,
                          input logic [1:0] b, input logic [1:0] c, input logic [1:0] d,
                          input int hold_cycles, input bit clr_on_eval, input string tag);
        int br;
        check({tag, " in_ready idle"}, 32'(in_ready_w), 32'd1);
        in_valid = 1'b1;
        in_y = y; in_z = z; in_b = b; in_c = c; in_d = d;
        step();                                   // accept edge N
        in_valid = 1'b0;
        junk_inputs();
        check({tag, " busy in_ready"}, 32'(in_ready_w), 32'd0);
        check({tag, " early out_valid"}, 32'(out_valid_w), 32'd0);
        clr_cnt = clr_on_eval;
        step();                                   // EVAL -> HOLD edge N+1
        clr_cnt = 1'b0;

        if (y < z) begin br = 0; m_a = b; end
        else if (y > z) begin br = 1; m_a = c; end
        else begin br = 2; m_a = d; end
        m_sel = 2'(br);
        if (clr_on_eval) begin
            m_cnt[0] = 0; m_cnt[1] = 0; m_cnt[2] = 0;
        end else begin
            m_cnt[br] = m_cnt[br] + 1;
        end

        check({tag, " out_valid"}, 32'(out_valid_w), 32'd1);
        check({tag, " out_valid2"}, 32'(out_valid_n), 32'd1);
        check({tag, " out_a"}, 32'(out_a_w), 32'(m_a));
        check({tag, " out_sel"}, 32'(out_sel_w), 32'(m_sel));
        check_counts(tag);

        out_ready = 1'b0;
        for (int i = 0; i < hold_cycles; i++) begin
            in_valid = 1'b1;                      // must be ignored while busy
            junk_inputs();
            step();
            check({tag, " hold out_valid"}, 32'(out_valid_w), 32'd1);
            check({tag, " hold out_a"}, 32'(out_a_w), 32'(m_a));
            check({tag, " hold out_sel"}, 32'(out_sel_w), 32'(m_sel));
            check({tag, " hold in_ready"}, 32'(in_ready_w), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();                                   // handshake edge
        out_ready = 1'b0;
        check({tag, " done out_valid"}, 32'(out_valid_w), 32'd0);
        check({tag, " done in_ready"}, 32'(in_ready_w), 32'd1);
        check({tag, " retained out_a"}, 32'(out_a_w), 32'(m_a));
        check({tag, " retained out_sel"}, 32'(out_sel_w), 32'(m_sel));
        check_counts({tag, " done"});
        $display("txn %s y=%0d z=%0d b=%0d c=%0d d=%0d hold=%0d clr=%0d -> a=%0d sel=%0d",
                 tag, y, z, b, c, d, hold_cycles, clr_on_eval, out_a_w, out_sel_w);
    endtask

    initial begin
        logic [3:0] ry, rz;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
        in_y = '0; in_z = '0; in_b = '0; in_c = '0; in_d = '0;
        m_cnt[0] = 0; m_cnt[1] = 0; m_cnt[2] = 0;
        m_a = '0; m_sel = '0;

        #2;
        check("rst in_ready", 32'(in_ready_w), 32'd0);
        check("rst out_valid", 32'(out_valid_w), 32'd0);
        check("rst out_a", 32'(out_a_w), 32'd0);
        check("rst out_sel", 32'(out_sel_w), 32'd0);
        check_counts("rst");
        step(); step();
        #2 reset = 1'b0;
        #1 check("post-rst in_ready", 32'(in_ready_w), 32'd1);
        step();
        check("post-rst in_ready edge", 32'(in_ready_w), 32'd1);

        // Directed cases: less-than, equal, greater-than.
        do_txn(4'd3, 4'd5, 2'd0, 2'd1, 2'd2, 0, 1'b0, "lt");
        do_txn(4'd5, 4'd5, 2'd0, 2'd1, 2'd2, 0, 1'b0, "eq");
        do_txn(4'd9, 4'd2, 2'd0, 2'd1, 2'd2, 0, 1'b0, "gt");
        // Backpressure with ignored requests during HOLD.
        do_txn(4'd1, 4'd14, 2'd3, 2'd1, 2'd2, 4, 1'b0, "bp");
        // Saturation: narrow counters stop at 3.
        for (int i = 0; i < 5; i++) do_txn(4'd0, 4'd15, 2'd1, 2'd2, 2'd3, 0, 1'b0, "sat");
        // Clear colliding with a less-than increment.
        do_txn(4'd2, 4'd7, 2'd3, 2'd0, 2'd1, 1, 1'b1, "clr");

        // Randomized requests, with equality made frequent.
        for (int i = 0; i < 40; i++) begin
            ry = 4'($urandom);
            rz = ($urandom_range(0, 3) == 0) ? ry : 4'($urandom);
            do_txn(ry, rz, 2'($urandom), 2'($urandom), 2'($urandom),
                   int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0), "rnd");
        end

        // Reset in the middle of HOLD, between clock edges.
        in_valid = 1'b1;
        in_y = 4'd4; in_z = 4'd8; in_b = 2'd3; in_c = 2'd1; in_d = 2'd2;
        step();
        in_valid = 1'b0;
        step();
        check("pre-rst hold out_valid", 32'(out_valid_w), 32'd1);
        #2 reset = 1'b1;
        #1;
        m_cnt[0] = 0; m_cnt[1] = 0; m_cnt[2] = 0;
        check("mid-rst out_valid", 32'(out_valid_w), 32'd0);
        check("mid-rst in_ready", 32'(in_ready_w), 32'd0);
        check("mid-rst out_a", 32'(out_a_w), 32'd0);
        check("mid-rst out_sel", 32'(out_sel_w), 32'd0);
        check_counts("mid-rst");
        #1 reset = 1'b0;
        #1 check("rel in_ready", 32'(in_ready_w), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("rel+1 in_ready", 32'(in_ready_w), 32'd1);
        check("rel+1 out_valid", 32'(out_valid_w), 32'd0);
        check_counts("rel+1");
        $display("txn reset-mid-hold dropped");

        // Service resumes normally after the reset.
        do_txn(4'd6, 4'd6, 2'd1, 2'd2, 2'd0, 1, 1'b0, "after-rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
